hpdcache_flush_sweep: RTL and testbench

- Flush-all sweeper that sits directly upstream of the flush controller and drives its ALLOC interface.
- On a flush-all command it walks every set of the cache directory and reads the dirty bits and tags of all ways.
- For each dirty line it issues one flush allocation and clears that line's dirty bit.
- It completes once the flush controller reports empty, meaning all write-backs have been acknowledged.

---
 rtl/hpdcache_flush_sweep_pkg.sv | 28 ++
 rtl/hpdcache_prio_1hot_encoder.sv | 29 ++
 rtl/hpdcache_flush_sweep.sv | 164 ++++++++++++++++
 tb/tb_hpdcache_flush_sweep.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_flush_sweep_pkg.sv
// Purpose: shared types and helpers for the flush-all directory sweeper.
// Latency: n/a (types and a combinational packing function only).
// Backpressure: n/a.
package hpdcache_flush_sweep_pkg;

    // Sweep FSM: read a set, capture its dirty/tag vectors, issue one
    // allocation per dirty way, then wait for the flush controller to drain.
    typedef enum logic [2:0] {
        SWEEP_IDLE,
        SWEEP_READ,
        SWEEP_CAPTURE,
        SWEEP_SCAN,
        SWEEP_DRAIN
    } sweep_state_e;

    // Widest nline the packing helper can build; callers cast down to their width.
    localparam int unsigned NLINE_MAX_W = 64;

    // Build a line address {tag, set} from a tag and a set index of set_width bits.
    function automatic logic [NLINE_MAX_W-1:0] pack_nline(
        input logic [NLINE_MAX_W-1:0] tag,
        input logic [NLINE_MAX_W-1:0] set,
        input int unsigned            set_width
    );
        return (tag << set_width) | set;
    endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Purpose: lowest-set-bit priority encoder, one-hot and binary index outputs.
// Latency: combinational.
// Backpressure: none.
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     val,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        onehot = '0;
        index  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (val[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IDX_W'(i);
            end
        end
    end

    assign found = |val;

endmodule

// File: rtl/hpdcache_flush_sweep.sv
// Purpose: flush-all sweeper; walks every directory set and allocates each dirty line to the flush controller.
// Latency: 3 cycles per clean set, plus one cycle per dirty line, plus drain until the flush controller is empty.
// Backpressure: holds dir read while grant is low, holds allocation stable while ready is low, waits in drain for empty.
module hpdcache_flush_sweep
    import hpdcache_flush_sweep_pkg::*;
#(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned TAG_WIDTH = 20,
    parameter int unsigned SET_WIDTH = $clog2(SETS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_i,
    output logic                           req_ready_o,
    output logic                           done_o,
    output logic                           busy_o,
    output logic                           dir_rd_o,
    output logic [SET_WIDTH-1:0]           dir_rd_set_o,
    input  logic                           dir_gnt_i,
    input  logic [WAYS-1:0]                dir_dirty_i,
    input  logic [WAYS*TAG_WIDTH-1:0]      dir_tag_i,
    output logic                           dir_clr_o,
    output logic [SET_WIDTH-1:0]           dir_clr_set_o,
    output logic [WAYS-1:0]                dir_clr_way_o,
    output logic                           flush_alloc_o,
    input  logic                           flush_alloc_ready_i,
    output logic [TAG_WIDTH+SET_WIDTH-1:0] flush_alloc_nline_o,
    output logic [WAYS-1:0]                flush_alloc_way_o,
    input  logic                           flush_empty_i
);

    localparam int unsigned WAY_IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned NLINE_W   = TAG_WIDTH + SET_WIDTH;
    localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(SETS - 1);

    sweep_state_e                  state_q, state_d;
    logic [SET_WIDTH-1:0]          set_q;
    logic [WAYS-1:0]               pending_q;
    logic [WAYS*TAG_WIDTH-1:0]     tags_q;

    logic                          set_load;
    logic                          set_inc;
    logic                          capture;
    logic                          alloc_fire;

    logic [WAYS-1:0]               sel_onehot;
    logic [WAY_IDX_W-1:0]          sel_idx;
    logic                          sel_found;
    logic [TAG_WIDTH-1:0]          sel_tag;

    hpdcache_prio_1hot_encoder #(
        .N     (WAYS),
        .IDX_W (WAY_IDX_W)
    ) u_sel_enc (
        .val    (pending_q),
        .onehot (sel_onehot),
        .index  (sel_idx),
        .found  (sel_found)
    );

    assign sel_tag = tags_q[32'(sel_idx)*TAG_WIDTH +: TAG_WIDTH];

    // State register; reset drops any sweep in progress straight back to idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SWEEP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep datapath: set cursor, captured dirty vector and tags of the current set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_q     <= '0;
            pending_q <= '0;
            tags_q    <= '0;
        end else begin
            if (set_load) begin
                set_q <= '0;
            end else if (set_inc) begin
                set_q <= set_q + SET_WIDTH'(1);
            end
            if (capture) begin
                pending_q <= dir_dirty_i;
                tags_q    <= dir_tag_i;
            end else if (alloc_fire) begin
                pending_q <= pending_q & ~sel_onehot;
            end
        end
    end

    // Next-state and output decode; outputs stay zero outside the state that owns them.
    always_comb begin
        state_d             = state_q;
        req_ready_o         = 1'b0;
        done_o              = 1'b0;
        busy_o              = (state_q != SWEEP_IDLE);
        dir_rd_o            = 1'b0;
        dir_rd_set_o        = '0;
        dir_clr_o           = 1'b0;
        dir_clr_set_o       = '0;
        dir_clr_way_o       = '0;
        flush_alloc_o       = 1'b0;
        flush_alloc_nline_o = '0;
        flush_alloc_way_o   = '0;
        set_load            = 1'b0;
        set_inc             = 1'b0;
        capture             = 1'b0;
        alloc_fire          = 1'b0;

        unique case (state_q)
            SWEEP_IDLE: begin
                req_ready_o = 1'b1;
                if (req_i) begin
                    set_load = 1'b1;
                    state_d  = SWEEP_READ;
                end
            end
            SWEEP_READ: begin
                dir_rd_o     = 1'b1;
                dir_rd_set_o = set_q;
                if (dir_gnt_i) begin
                    state_d = SWEEP_CAPTURE;
                end
            end
            SWEEP_CAPTURE: begin
                capture = 1'b1;
                state_d = SWEEP_SCAN;
            end
            SWEEP_SCAN: begin
                if (sel_found) begin
                    flush_alloc_o       = 1'b1;
                    flush_alloc_nline_o = NLINE_W'(pack_nline(NLINE_MAX_W'(sel_tag),
                                                              NLINE_MAX_W'(set_q),
                                                              SET_WIDTH));
                    flush_alloc_way_o   = sel_onehot;
                    if (flush_alloc_ready_i) begin
                        alloc_fire    = 1'b1;
                        dir_clr_o     = 1'b1;
                        dir_clr_set_o = set_q;
                        dir_clr_way_o = sel_onehot;
                    end
                end else if (set_q == LAST_SET) begin
                    state_d = SWEEP_DRAIN;
                end else begin
                    set_inc = 1'b1;
                    state_d = SWEEP_READ;
                end
            end
            SWEEP_DRAIN: begin
                if (flush_empty_i) begin
                    done_o  = 1'b1;
                    state_d = SWEEP_IDLE;
                end
            end
            default: begin
                state_d = SWEEP_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hpdcache_flush_sweep.sv
// Purpose: self-checking bench for the flush-all sweeper against a directory/flush-controller model.
// Latency: checks the clean-sweep latency and per-line allocation timing.
// Backpressure: exercises grant, allocation-ready and drain-empty stalls.
module tb_hpdcache_flush_sweep;

    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int TW   = 8;
    localparam int SW   = 2;
    localparam int NW   = TW + SW;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic              req_ready_o;
    logic              done_o;
    logic              busy_o;
    logic              dir_rd_o;
    logic [SW-1:0]     dir_rd_set_o;
    logic              dir_gnt_i = 1'b0;
    logic [WAYS-1:0]   dir_dirty_i = '0;
    logic [WAYS*TW-1:0] dir_tag_i = '0;
    logic              dir_clr_o;
    logic [SW-1:0]     dir_clr_set_o;
    logic [WAYS-1:0]   dir_clr_way_o;
    logic              flush_alloc_o;
    logic              flush_alloc_ready_i = 1'b0;
    logic [NW-1:0]     flush_alloc_nline_o;
    logic [WAYS-1:0]   flush_alloc_way_o;
    logic              flush_empty_i = 1'b0;

    hpdcache_flush_sweep #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .TAG_WIDTH (TW),
        .SET_WIDTH (SW)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .req_i               (req_i),
        .req_ready_o         (req_ready_o),
        .done_o              (done_o),
        .busy_o              (busy_o),
        .dir_rd_o            (dir_rd_o),
        .dir_rd_set_o        (dir_rd_set_o),
        .dir_gnt_i           (dir_gnt_i),
        .dir_dirty_i         (dir_dirty_i),
        .dir_tag_i           (dir_tag_i),
        .dir_clr_o           (dir_clr_o),
        .dir_clr_set_o       (dir_clr_set_o),
        .dir_clr_way_o       (dir_clr_way_o),
        .flush_alloc_o       (flush_alloc_o),
        .flush_alloc_ready_i (flush_alloc_ready_i),
        .flush_alloc_nline_o (flush_alloc_nline_o),
        .flush_alloc_way_o   (flush_alloc_way_o),
        .flush_empty_i       (flush_empty_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NW-1:0]   nline;
        logic [WAYS-1:0] way;
    } alloc_t;

    // Directory contents as the cache holds them.
    logic            dirty_m [SETS][WAYS];
    logic [TW-1:0]   tag_m   [SETS][WAYS];

    // Scoreboard queues filled when a sweep is launched.
    alloc_t exp_alloc[$];
    int     exp_rd[$];
    int     exp_done = 0;

    int errors = 0;
    int checks = 0;

    // Stimulus knobs.
    int gnt_low_left = 0;
    int ready_low_left = 0;
    bit gnt_rand = 0;
    bit ready_rand = 0;
    bit empty_rand = 0;
    bit empty_val = 1;

    // Monitor bookkeeping.
    int            cyc = 0;
    bit            rd_hit = 0;
    logic [SW-1:0] rd_set = '0;
    int            acc_cyc = 0;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            rd_total = 0;
    int            clr_total = 0;
    int            held_cnt = 0;
    int            accepts[$];
    logic [NW-1:0] last_nline = '0;
    alloc_t        head;
    int            ci;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected activity 0x%0h, expected none (t=%0t)", name, act, $time);
    endtask

    function automatic int oh2idx(input logic [WAYS-1:0] v);
        int r = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Input driver: one update per cycle, just after the rising edge.
    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (gnt_low_left > 0 && dir_rd_o) begin
                dir_gnt_i = 1'b0;
                gnt_low_left--;
            end else begin
                dir_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ready_low_left > 0 && flush_alloc_o) begin
                flush_alloc_ready_i = 1'b0;
                ready_low_left--;
            end else begin
                flush_alloc_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            flush_empty_i = empty_rand ? 1'($urandom_range(0, 1)) : empty_val;
            if (rd_hit) begin
                for (int w = 0; w < WAYS; w++) begin
                    dir_dirty_i[w]           = dirty_m[rd_set][w];
                    dir_tag_i[w*TW +: TW]    = tag_m[rd_set][w];
                end
            end else begin
                dir_dirty_i = WAYS'($urandom);
                dir_tag_i   = (WAYS*TW)'($urandom);
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard at the falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            rd_hit = 0;
            if (rst_ni) begin
                if (req_i && req_ready_o) acc_cyc = cyc;
                if (dir_rd_o) begin
                    if (exp_rd.size() == 0) begin
                        unexpected("dir_rd", 32'(dir_rd_set_o));
                    end else begin
                        chk("rd_set", 32'(dir_rd_set_o), 32'(exp_rd[0]));
                        if (dir_gnt_i) begin
                            void'(exp_rd.pop_front());
                            rd_hit = 1;
                            rd_set = dir_rd_set_o;
                            rd_total++;
                        end
                    end
                end
                if (flush_alloc_o) begin
                    if (exp_alloc.size() == 0) begin
                        unexpected("alloc", 32'(flush_alloc_nline_o));
                    end else begin
                        head = exp_alloc[0];
                        chk("alloc_nline", 32'(flush_alloc_nline_o), 32'(head.nline));
                        chk("alloc_way", 32'(flush_alloc_way_o), 32'(head.way));
                        if (flush_alloc_ready_i) begin
                            chk("clr_vld", 32'(dir_clr_o), 32'd1);
                            chk("clr_set", 32'(dir_clr_set_o), 32'(head.nline[SW-1:0]));
                            chk("clr_way", 32'(dir_clr_way_o), 32'(head.way));
                            void'(exp_alloc.pop_front());
                            accepts.push_back(cyc);
                            last_nline = flush_alloc_nline_o;
                            clr_total++;
                        end else begin
                            chk("clr_while_stalled", 32'(dir_clr_o), 32'd0);
                            held_cnt++;
                        end
                    end
                end else if (dir_clr_o) begin
                    unexpected("dir_clr_no_alloc", 32'(dir_clr_way_o));
                end
                // The directory obeys whatever clear the sweeper issues.
                if (dir_clr_o) begin
                    ci = oh2idx(dir_clr_way_o);
                    if (ci >= 0) dirty_m[dir_clr_set_o][ci] = 1'b0;
                end
                if (done_o) begin
                    chk("done_needs_empty", 32'(flush_empty_i), 32'd1);
                    chk("done_expected", 32'(exp_done), 32'd1);
                    chk("done_allocs_left", 32'(exp_alloc.size()), 32'd0);
                    chk("done_reads_left", 32'(exp_rd.size()), 32'd0);
                    exp_done = 0;
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_model();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                dirty_m[s][w] = 1'b0;
                tag_m[s][w]   = TW'($urandom);
            end
    endtask

    // Reference: every set read once in order; each dirty line allocated
    // once, lower sets first and lower ways first within a set.
    task automatic launch();
        alloc_t a;
        exp_rd.delete();
        exp_alloc.delete();
        for (int s = 0; s < SETS; s++) begin
            exp_rd.push_back(s);
            for (int w = 0; w < WAYS; w++) begin
                if (dirty_m[s][w]) begin
                    a.nline = {tag_m[s][w], SW'(s)};
                    a.way   = WAYS'(1 << w);
                    exp_alloc.push_back(a);
                end
            end
        end
        exp_done = 1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 50 && !req_ready_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        chk("launch_ready", 32'(req_ready_o), 32'd1);
        req_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == start; i++) @(posedge clk_i);
        chk("done_seen", 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        int c0, r0, h0, d0;
        clear_model();

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_dir_rd", 32'(dir_rd_o), 32'd0);
        chk("rst_alloc", 32'(flush_alloc_o), 32'd0);
        chk("rst_dir_clr", 32'(dir_clr_o), 32'd0);
        rst_ni = 1'b1;

        // All clean, grant and empty high: four reads, no allocs, done at cycle 13.
        c0 = clr_total; r0 = rd_total;
        launch();
        wait_done();
        chk("clean_latency", 32'(done_cyc - acc_cyc), 32'(3*SETS + 1));
        chk("clean_reads", 32'(rd_total - r0), 32'(SETS));
        chk("clean_allocs", 32'(clr_total - c0), 32'd0);

        // One dirty line: set 2 way 1, tag 0x15.
        clear_model();
        dirty_m[2][1] = 1'b1;
        tag_m[2][1]   = 8'h15;
        c0 = clr_total;
        launch();
        wait_done();
        chk("single_allocs", 32'(clr_total - c0), 32'd1);
        chk("single_nline", 32'(last_nline), 32'h56);

        // Two dirty ways in set 1 with ready held high: consecutive cycles.
        clear_model();
        dirty_m[1][0] = 1'b1;
        dirty_m[1][1] = 1'b1;
        accepts.delete();
        launch();
        wait_done();
        chk("b2b_count", 32'(accepts.size()), 32'd2);
        if (accepts.size() == 2) chk("b2b_gap", 32'(accepts[1] - accepts[0]), 32'd1);

        // Allocation ready low for five cycles.
        clear_model();
        dirty_m[3][0] = 1'b1;
        c0 = clr_total; h0 = held_cnt;
        ready_low_left = 5;
        launch();
        wait_done();
        chk("stall_held_cycles", 32'(held_cnt - h0), 32'd5);
        chk("stall_single_clr", 32'(clr_total - c0), 32'd1);

        // Grant low for three cycles on set 0: capture only after the grant.
        clear_model();
        r0 = rd_total;
        gnt_low_left = 3;
        launch();
        wait_done();
        chk("gnt_stall_latency", 32'(done_cyc - acc_cyc), 32'(3*SETS + 1 + 3));
        chk("gnt_stall_reads", 32'(rd_total - r0), 32'(SETS));

        // Reset during a scan: dirty bits survive, next sweep finds them all.
        clear_model();
        dirty_m[0][0] = 1'b1;
        dirty_m[2][1] = 1'b1;
        dirty_m[3][0] = 1'b1;
        dirty_m[3][1] = 1'b1;
        ready_low_left = 3;
        launch();
        for (int i = 0; i < 100 && !flush_alloc_o; i++) @(negedge clk_i);
        chk("reset_reached_scan", 32'(flush_alloc_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        exp_alloc.delete();
        exp_rd.delete();
        exp_done = 0;
        ready_low_left = 0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_req_ready", 32'(req_ready_o), 32'd1);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_alloc", 32'(flush_alloc_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        d0 = done_cnt;
        repeat (5) @(posedge clk_i);
        chk("postrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("postrst_idle", 32'(busy_o), 32'd0);
        c0 = clr_total;
        launch();
        wait_done();
        chk("postrst_allocs", 32'(clr_total - c0), 32'd4);

        // Drain with empty held low: done only after empty rises.
        clear_model();
        dirty_m[1][1] = 1'b1;
        empty_val = 0;
        d0 = done_cnt;
        launch();
        for (int i = 0; i < 200 && (exp_rd.size() != 0 || exp_alloc.size() != 0); i++) @(posedge clk_i);
        repeat (10) @(posedge clk_i);
        #1;
        chk("drain_no_done", 32'(done_cnt - d0), 32'd0);
        chk("drain_busy", 32'(busy_o), 32'd1);
        empty_val = 1;
        wait_done();

        // Randomized sweeps with random stalls on every handshake.
        gnt_rand = 1;
        ready_rand = 1;
        empty_rand = 1;
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    dirty_m[s][w] = ($urandom_range(0, 99) < 40);
                    tag_m[s][w]   = TW'($urandom);
                end
            c0 = 0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    if (dirty_m[s][w]) c0++;
            r0 = clr_total;
            launch();
            wait_done();
            chk("rand_alloc_count", 32'(clr_total - r0), 32'(c0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
